// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder: rounding modes, flag layout
// and the canonical-NaN / largest-finite bit patterns for any field widths.
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_NV = 3;

  localparam int FP_MAX_W = 128;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  function automatic logic [FP_MAX_W-1:0] qnan_const(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
    v[man_w-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [FP_MAX_W-1:0] max_finite(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < man_w; i++) v[i] = 1'b1;
    for (int i = 1; i < exp_w; i++) v[man_w+i] = 1'b1;
    return v;
  endfunction

  // Reserved encodings fall back to round-to-nearest-even.
  function automatic logic [2:0] rm_norm(input logic [2:0] rm);
    return (rm > RM_RMM) ? RM_RNE : rm;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero vector reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-style adder/subtractor: S1 unpack/align, S2 add/normalise,
// S3 round/pack. All stages advance together under a single enable.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     fp_a,
  input  logic [EXP_W+MAN_W:0]     fp_b,
  input  logic                     op_sub,
  input  logic [2:0]               r_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     fp_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 4;              // hidden + fraction + guard/round/sticky
  localparam int SH_W = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W:0]   EXP_OVF = {1'b0, {EXP_W{1'b1}}};
  localparam logic [FP_MAX_W-1:0] QNAN_FULL = qnan_const(EXP_W, MAN_W);
  localparam logic [FP_MAX_W-1:0] MAXF_FULL = max_finite(EXP_W, MAN_W);
  localparam logic [W-1:0] QNAN = QNAN_FULL[W-1:0];
  localparam logic [W-1:0] MAXF = MAXF_FULL[W-1:0];

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: unpack, special detect, align ----------------
  logic                 a_sign, b_sign;
  logic [EXP_W-1:0]     a_exp, b_exp;
  logic [MAN_W-1:0]     a_man, b_man;
  logic                 a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_big;

  assign a_sign = fp_a[W-1];
  assign b_sign = fp_b[W-1] ^ op_sub;
  assign a_exp  = fp_a[W-2:MAN_W];
  assign b_exp  = fp_b[W-2:MAN_W];
  assign a_man  = fp_a[MAN_W-1:0];
  assign b_man  = fp_b[MAN_W-1:0];
  assign a_nan  = (a_exp == EXP_MAX) && (a_man != '0);
  assign b_nan  = (b_exp == EXP_MAX) && (b_man != '0);
  assign a_snan = a_nan && !a_man[MAN_W-1];
  assign b_snan = b_nan && !b_man[MAN_W-1];
  assign a_inf  = (a_exp == EXP_MAX) && (a_man == '0);
  assign b_inf  = (b_exp == EXP_MAX) && (b_man == '0);
  assign a_big  = fp_a[W-2:0] >= fp_b[W-2:0];

  logic [EXP_W-1:0] big_exp, small_exp, big_eexp, small_eexp, exp_diff;
  logic [MAN_W-1:0] big_man, small_man;
  logic             big_sign, small_sign;
  logic [SH_W-1:0]  shamt;
  logic [SW-1:0]    big_sig, small_sig, small_shr, small_aln;
  logic             lost;
  logic             spec, spec_nv;
  logic [W-1:0]     spec_res;

  always_comb begin
    big_exp    = a_big ? a_exp  : b_exp;
    small_exp  = a_big ? b_exp  : a_exp;
    big_man    = a_big ? a_man  : b_man;
    small_man  = a_big ? b_man  : a_man;
    big_sign   = a_big ? a_sign : b_sign;
    small_sign = a_big ? b_sign : a_sign;
    big_eexp   = (big_exp == '0) ? EXP_W'(1) : big_exp;
    small_eexp = (small_exp == '0) ? EXP_W'(1) : small_exp;
    exp_diff   = big_eexp - small_eexp;
    shamt      = (32'(exp_diff) > SW - 1) ? SH_W'(SW - 1) : SH_W'(exp_diff);
    big_sig    = {big_exp != '0, big_man, 3'b000};
    small_sig  = {small_exp != '0, small_man, 3'b000};
    small_shr  = small_sig >> shamt;
    lost       = |(small_sig & ~({SW{1'b1}} << shamt));
    small_aln  = {small_shr[SW-1:1], small_shr[0] | lost};

    spec     = a_nan || b_nan || a_inf || b_inf;
    spec_nv  = 1'b0;
    spec_res = QNAN;
    if (a_nan || b_nan) begin
      spec_nv = a_snan || b_snan;
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      spec_nv = 1'b1;
    end else if (a_inf) begin
      spec_res = {a_sign, EXP_MAX, {MAN_W{1'b0}}};
    end else begin
      spec_res = {b_sign, EXP_MAX, {MAN_W{1'b0}}};
    end
  end

  logic             s1_valid, s1_big_sign, s1_small_sign, s1_eff_sub, s1_spec, s1_spec_nv;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0]    s1_big_sig, s1_small_sig;
  logic [W-1:0]     s1_spec_res;
  logic [2:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_big_sign   <= big_sign;
      s1_small_sign <= small_sign;
      s1_eff_sub    <= a_sign ^ b_sign;
      s1_exp        <= big_eexp;
      s1_big_sig    <= big_sig;
      s1_small_sig  <= small_aln;
      s1_spec       <= spec;
      s1_spec_nv    <= spec_nv;
      s1_spec_res   <= spec_res;
      s1_rm         <= rm_norm(r_mode);
      s1_tag        <= in_tag;
    end
  end

  // ---------------- S2: add/subtract, normalise ----------------
  logic [SW:0]      sum;
  logic [SH_W-1:0]  lz, nshift;
  logic [EXP_W-1:0] exp_lim;
  logic [SW-1:0]    norm_sig;
  logic [EXP_W:0]   norm_exp;
  logic             res_sign;

  fp_lzc #(.WIDTH(SW), .CNT_W(SH_W)) u_lzc (
    .vec   (sum[SW-1:0]),
    .count (lz)
  );

  always_comb begin
    sum     = s1_eff_sub ? ({1'b0, s1_big_sig} - {1'b0, s1_small_sig})
                         : ({1'b0, s1_big_sig} + {1'b0, s1_small_sig});
    exp_lim = s1_exp - 1'b1;
    // Never normalise below the minimum exponent: the result stays subnormal.
    nshift  = (32'(lz) > 32'(exp_lim)) ? SH_W'(exp_lim) : lz;
    if (sum[SW]) begin
      norm_sig = {sum[SW:2], sum[1] | sum[0]};
      norm_exp = {1'b0, s1_exp} + 1'b1;
    end else begin
      norm_sig = sum[SW-1:0] << nshift;
      norm_exp = {1'b0, s1_exp} - (EXP_W+1)'(nshift);
    end
    if (sum == '0)
      res_sign = (s1_big_sign && s1_small_sign) || ((s1_rm == RM_RDN) && s1_eff_sub);
    else
      res_sign = s1_big_sign;
  end

  logic             s2_valid, s2_sign, s2_spec, s2_spec_nv;
  logic [EXP_W:0]   s2_exp;
  logic [SW-1:0]    s2_sig;
  logic [W-1:0]     s2_spec_res;
  logic [2:0]       s2_rm;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk) begin
    if (adv) begin
      s2_sign     <= res_sign;
      s2_exp      <= norm_exp;
      s2_sig      <= norm_sig;
      s2_spec     <= s1_spec;
      s2_spec_nv  <= s1_spec_nv;
      s2_spec_res <= s1_spec_res;
      s2_rm       <= s1_rm;
      s2_tag      <= s1_tag;
    end
  end

  // ---------------- S3: round, pack, flags ----------------
  logic [MAN_W:0]   man;
  logic [MAN_W+1:0] man_r;
  logic [MAN_W-1:0] frac_r;
  logic [EXP_W:0]   exp_r;
  logic             grd, stk, inexact, up, ovf, ovf_inf;
  logic [W-1:0]     s3_res;
  fp_flags_t        s3_flags;

  always_comb begin
    man     = s2_sig[SW-1:3];
    grd     = s2_sig[2];
    stk     = |s2_sig[1:0];
    inexact = grd || stk;
    case (s2_rm)
      RM_RNE:  up = grd && (stk || man[0]);
      RM_RDN:  up = s2_sign && inexact;
      RM_RUP:  up = !s2_sign && inexact;
      RM_RMM:  up = grd;
      default: up = 1'b0;
    endcase
    man_r = {1'b0, man} + (MAN_W+2)'(up);
    if (man_r[MAN_W+1]) begin
      exp_r  = s2_exp + 1'b1;
      frac_r = man_r[MAN_W:1];
    end else begin
      exp_r  = man_r[MAN_W] ? s2_exp : '0;
      frac_r = man_r[MAN_W-1:0];
    end
    ovf     = exp_r >= EXP_OVF;
    ovf_inf = (s2_rm == RM_RNE) || (s2_rm == RM_RMM) ||
              ((s2_rm == RM_RUP) && !s2_sign) || ((s2_rm == RM_RDN) && s2_sign);

    s3_res      = {s2_sign, exp_r[EXP_W-1:0], frac_r};
    s3_flags    = '0;
    s3_flags.nx = inexact;
    s3_flags.uf = inexact && (exp_r == '0);
    if (s2_spec) begin
      s3_res      = s2_spec_res;
      s3_flags    = '0;
      s3_flags.nv = s2_spec_nv;
    end else if (ovf) begin
      s3_res      = ovf_inf ? {s2_sign, EXP_MAX, {MAN_W{1'b0}}} : {s2_sign, MAXF[W-2:0]};
      s3_flags    = '0;
      s3_flags.of = 1'b1;
      s3_flags.nx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      fp_result <= '0;
      out_tag   <= '0;
      flags     <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        fp_result <= s3_res;
        out_tag   <= s2_tag;
        flags     <= s3_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe: directed corner cases, stall/reset
// behaviour, then randomized traffic against an exact-arithmetic model.
module tb_fp_add_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int TAG_W = 4;
  localparam int W     = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [W-1:0]     fp_a, fp_b, fp_result;
  logic [2:0]       r_mode;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [3:0]       flags;

  int n_tests = 0;
  int n_fail  = 0;

  fp_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fp_a(fp_a), .fp_b(fp_b), .op_sub(op_sub), .r_mode(r_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .fp_result(fp_result),
    .out_tag(out_tag), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Exact reference: every finite value becomes an integer count of the
  // smallest subnormal, the sum is exact, then rounded once to the format.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic [2:0] rm_in);
    logic sa, sb, sr, nx, up, inf_sel;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
    logic [287:0] va, vb, mag, q, rem, half;
    logic [2:0] rm;
    int p, e, sh;
    rm = (rm_in > 3'd4) ? 3'd0 : rm_in;
    sa = a[31]; sb = b[31] ^ sub;
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    a_nan = (ea == 8'hFF) && (fa != 0); b_nan = (eb == 8'hFF) && (fb != 0);
    a_inf = (ea == 8'hFF) && (fa == 0); b_inf = (eb == 8'hFF) && (fb == 0);
    a_snan = a_nan && !fa[22]; b_snan = b_nan && !fb[22];
    if (a_nan || b_nan) return {a_snan || b_snan, 3'b000, 32'h7FC00000};
    if (a_inf && b_inf && sa != sb) return {4'b1000, 32'h7FC00000};
    if (a_inf) return {4'b0000, sa, 8'hFF, 23'd0};
    if (b_inf) return {4'b0000, sb, 8'hFF, 23'd0};
    va = 288'({ea != 0, fa}) << ((ea == 0) ? 0 : int'(ea) - 1);
    vb = 288'({eb != 0, fb}) << ((eb == 0) ? 0 : int'(eb) - 1);
    if (sa == sb) begin mag = va + vb; sr = sa; end
    else if (va >= vb) begin mag = va - vb; sr = sa; end
    else begin mag = vb - va; sr = sb; end
    if (mag == 0) begin
      sr = (sa && sb) || (rm == 3'd2 && sa != sb);
      return {4'b0000, sr, 31'd0};
    end
    p = 0;
    for (int i = 0; i < 288; i++) if (mag[i]) p = i;
    if (p <= 23) return {4'b0000, sr, 7'd0, mag[23], mag[22:0]};
    e = p - 22; sh = e - 1;
    q = mag >> sh;
    rem = mag - (q << sh);
    half = 288'(1) << (sh - 1);
    nx = (rem != 0);
    case (rm)
      3'd0: up = (rem > half) || (rem == half && q[0]);
      3'd1: up = 1'b0;
      3'd2: up = sr && nx;
      3'd3: up = !sr && nx;
      default: up = (rem >= half);
    endcase
    q = q + 288'(up);
    if (q[24]) begin q = q >> 1; e++; end
    if (e >= 255) begin
      inf_sel = (rm == 3'd0) || (rm == 3'd4) || (rm == 3'd3 && !sr) || (rm == 3'd2 && sr);
      return {4'b0101, inf_sel ? {sr, 8'hFF, 23'd0} : {sr, 8'hFE, 23'h7FFFFF}};
    end
    return {3'b000, nx, sr, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] gen_op();
    logic s;
    logic [7:0] e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 11))
      0: return {s, 31'd0};
      1: return {s, 8'hFF, 23'd0};
      2: return {s, 8'hFF, 1'($urandom_range(0, 1)), 22'($urandom_range(1, 4194303))};
      3: return {s, 8'd0, f};
      4: e = 8'($urandom_range(250, 254));
      5: e = 8'($urandom_range(1, 3));
      default: e = 8'($urandom_range(100, 150));
    endcase
    return {s, e, f};
  endfunction

  task automatic run_dir(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [2:0] rm,
                         input logic [31:0] er, input logic [3:0] ef);
    @(posedge clk); #1;
    in_valid = 1'b1; fp_a = a; fp_b = b; op_sub = sub; r_mode = rm; in_tag = 4'd7;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, "_lat2"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_res"}, 64'(fp_result), 64'(er));
    chk({name, "_flags"}, 64'(flags), 64'(ef));
  endtask

  task automatic push3(input logic rdy);
    @(posedge clk); #1;
    out_ready = rdy; in_valid = 1'b1; op_sub = 1'b0; r_mode = 3'd0;
    fp_a = 32'h3F800000; fp_b = 32'h3F800000; in_tag = 4'd1;
    @(posedge clk); #1;
    fp_b = 32'h40000000; in_tag = 4'd2;
    @(posedge clk); #1;
    fp_a = 32'h40000000; in_tag = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [39:0] exp_q[$];
  logic [39:0] cur, held_val, e_item;
  logic [35:0] m;
  logic        held, seen;
  logic [3:0]  tag_ctr;

  initial begin
    rst = 1'b1; in_valid = 1'b0; fp_a = '0; fp_b = '0; op_sub = 1'b0;
    r_mode = 3'd0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'({fp_result, out_tag, flags}), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_dir("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h40000000, 4'b0000);
    run_dir("subn_add", 32'h000A0000, 32'h000A0000, 1'b0, 3'd1, 32'h00140000, 4'b0000);
    run_dir("cancel_rdn", 32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 32'h80000000, 4'b0000);
    run_dir("ovf_rne", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 4'b0101);
    run_dir("ovf_rtz", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 32'h7F7FFFFF, 4'b0101);
    run_dir("inf_m_inf", 32'h7F800000, 32'hFF800000, 1'b0, 3'd0, 32'h7FC00000, 4'b1000);
    run_dir("cancel_rne", 32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 32'h00000000, 4'b0000);

    // stall: three back-to-back operations held behind out_ready=0
    push3(1'b0);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", 64'({out_valid, in_ready, out_tag, fp_result}),
          64'({1'b1, 1'b0, 4'd1, 32'h40000000}));
    end
    out_ready = 1'b1;
    chk("stall_t1", 64'({out_valid, out_tag, fp_result}), 64'({1'b1, 4'd1, 32'h40000000}));
    @(posedge clk); #1;
    chk("stall_t2", 64'({out_valid, out_tag, fp_result}), 64'({1'b1, 4'd2, 32'h40400000}));
    @(posedge clk); #1;
    chk("stall_t3", 64'({out_valid, out_tag, fp_result}), 64'({1'b1, 4'd3, 32'h40800000}));
    @(posedge clk); #1;
    chk("stall_empty", 64'(out_valid), 64'd0);

    // reset with operations in flight
    push3(1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_regs", 64'({in_ready, fp_result, out_tag, flags}), 64'({1'b1, 40'd0}));
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_no_ghost", 64'(seen), 64'd0);

    // randomized traffic with random backpressure
    held = 1'b0; tag_ctr = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      fp_a   = gen_op();
      fp_b   = ($urandom_range(0, 2) == 0) ? {1'($urandom_range(0, 1)), fp_a[30:0] ^ 31'($urandom_range(0, 1023))}
                                           : gen_op();
      op_sub = 1'($urandom_range(0, 1));
      r_mode = 3'($urandom_range(0, 7));
      in_tag = tag_ctr;
      @(negedge clk);
      cur = {out_tag, flags, fp_result};
      if (held) chk("hold_stable", 64'({out_valid, cur}), 64'({1'b1, held_val}));
      held = out_valid && !out_ready;
      held_val = cur;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 64'(cur), 64'd0);
        else begin
          e_item = exp_q.pop_front();
          chk("rand_out", 64'(cur), 64'(e_item));
        end
      end
      if (in_valid && in_ready) begin
        m = ref_add(fp_a, fp_b, op_sub, r_mode);
        exp_q.push_back({tag_ctr, m});
        tag_ctr = tag_ctr + 1'b1;
      end
    end

    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        e_item = exp_q.pop_front();
        chk("drain_out", 64'({out_tag, flags, fp_result}), 64'(e_item));
      end
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter TAG_W, default 4, width of the user tag carried alongside each operation.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, operands present.
REQ-007 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-008 SHALL have port fp_a, input, W, operand A.
REQ-009 SHALL have port fp_b, input, W, operand B.
REQ-010 SHALL have port op_sub, input, 1, 1 = compute A-B (B sign inverted).
REQ-011 SHALL have port r_mode, input, 3, 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-012 SHALL have port in_tag, input, TAG_W, opaque tag.
REQ-013 SHALL have port out_valid, output, 1, result present.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-015 SHALL have port fp_result, output, W, rounded sum.
REQ-016 SHALL have port out_tag, output, TAG_W, tag of the operation producing fp_result.
REQ-017 SHALL have port flags, output, 4, {invalid, overflow, underflow, inexact}.

Function
REQ-018 SHALL use a 3-stage pipeline: S1 unpack/special-detect/align, S2 add-subtract/leading-zero normalise, S3 round/pack/flags.
REQ-019 SHALL accept an operation on a rising edge where in_valid && in_ready; result becomes visible with out_valid=1 after exactly 3 edges when there is no stall.
REQ-020 SHALL advance all stages together with enable adv = !out_valid || out_ready; in_ready = adv; bubbles are not squeezed.
REQ-021 SHALL hold fp_result, out_tag and flags stable while out_valid && !out_ready.
REQ-022 SHALL deliver results in acceptance order, one per accepted input, none lost or duplicated.
REQ-023 SHALL keep guard, round and sticky bits through alignment; bits shifted beyond sticky are ORed into sticky; shift amount saturates at MAN_W+3.
REQ-024 SHALL treat exponent 0 as subnormal, with effective exponent 1 and hidden bit 0, in both alignment and output.
REQ-025 SHALL, on normalise, increment the exponent on carry-out, and left-shift by the leading-zero count limited so the exponent does not drop below 1, producing a subnormal output otherwise.
REQ-026 SHALL round per r_mode on the result sign, with r_mode 101-111 treated as RNE; mantissa carry from rounding increments the exponent.
REQ-027 SHALL, on overflow, return infinity for RNE/RMM, for RUP when positive and for RDN when negative; otherwise return max finite; overflow=1 and inexact=1.
REQ-028 SHALL set underflow=1 when the result is tiny after rounding and inexact.
REQ-029 SHALL return canonical quiet NaN (sign 0, exponent all ones, fraction MSB only) for any NaN operand or inf-inf; invalid=1 for inf-inf or a signalling NaN operand.
REQ-030 SHALL return infinity, sign preserved, flags 0, when exactly one operand is infinite or both are infinite with equal signs.
REQ-031 SHALL give an exact-zero result sign 1 only when both effective signs are 1, or under RDN for opposite-sign cancellation; otherwise sign 0.

Reset
REQ-032 SHALL, while rst=1, force all stage valid bits and out_valid to 0, fp_result, out_tag and flags to 0, and in_ready to 1.
REQ-033 SHALL discard all in-flight operations when reset is asserted mid-operation; no result for them appears after release.

Structure
REQ-034 SHALL place rounding-mode encodings, the flag bit indices and the canonical-NaN/max-finite constant functions in a shared package fp_pkg.
REQ-035 SHALL instantiate a single sub-module fp_lzc (parametrised leading-zero counter) in S2.

Verification
REQ-036 SHALL cover 0x3F800000 + 0x3F800000, RNE, out_ready=1 -> 0x40000000 3 cycles later, flags 0000.
REQ-037 SHALL cover 0x000A0000 + 0x000A0000, RTZ -> 0x00140000; and 0x3F800000 - 0x3F800000 (op_sub=1), RDN -> 0x80000000.
REQ-038 SHALL cover 0x7F7FFFFF + 0x7F7FFFFF: RNE -> 0x7F800000, flags 0101; RTZ -> 0x7F7FFFFF, flags 0101.
REQ-039 SHALL cover 0x7F800000 + 0xFF800000 -> 0x7FC00000, flags 1000.
REQ-040 SHALL cover 3 back-to-back pushes with tags 1,2,3 and out_ready=0 for 5 cycles -> in_ready=0 once output held, result unchanged, then tags 1,2,3 in order.
REQ-041 SHALL cover rst pulsed with 2 operations in flight -> out_valid=0 immediately and no result emitted after release.
